// File: rtl/dcsk_tx_pkg.sv
// Shared types and helpers for the DCSK transmit scheduler.
// Holds the FSM state type, chip index width and SF-to-log2 mapping.
package dcsk_tx_pkg;

    import spreading_factors_pkg::*;

    localparam int CHIP_IDX_W = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SEND  = 2'd2,
        GUARD = 2'd3
    } tx_sched_state_t;

    // log2 of the spreading factor; also the chip-index bit that
    // separates the reference half from the data half.
    function automatic logic [2:0] sf_to_log2(input logic [1:0] sf);
        logic [2:0] l;
        unique case (sf)
            SF2:     l = 3'd1;
            SF4:     l = 3'd2;
            SF8:     l = 3'd3;
            default: l = 3'd4;
        endcase
        return l;
    endfunction

endpackage

// File: rtl/spreading_factors_pkg.sv
// Spreading-factor encodings shared by the DCSK transmit path.
// SF2/SF4/SF8/SF16 are carried on a 2-bit field.
package spreading_factors_pkg;

    typedef enum logic [1:0] {
        SF2  = 2'd0,
        SF4  = 2'd1,
        SF8  = 2'd2,
        SF16 = 2'd3
    } sf_t;

endpackage

// File: rtl/dcsk_tx_scheduler_chip_bit_counter.sv
// chip_bit_counter: chip index within a bit, bit index within a frame.
// Ports: i_clk, i_arst, i_clear, i_enable, i_sf -> o_chip_idx,
//        o_chip_idx_msb (registered half select), o_last_chip_of_frame.
module chip_bit_counter
    import dcsk_tx_pkg::*;
#(
    parameter int MSG_WIDTH = 32
) (
    input  logic                  i_clk,
    input  logic                  i_arst,
    input  logic                  i_clear,
    input  logic                  i_enable,
    input  logic [1:0]            i_sf,
    output logic [CHIP_IDX_W-1:0] o_chip_idx,
    output logic                  o_chip_idx_msb,
    output logic                  o_last_chip_of_frame
);

    localparam int BIT_W = (MSG_WIDTH > 1) ? $clog2(MSG_WIDTH) : 1;
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(MSG_WIDTH - 1);
    localparam logic [CHIP_IDX_W:0] SPAN_UNIT = (CHIP_IDX_W+1)'(2);

    logic [CHIP_IDX_W-1:0] r_chip;
    logic                  r_msb;
    logic [BIT_W-1:0]      r_bit;

    logic [2:0]            w_log2;
    logic [CHIP_IDX_W:0]   w_span;
    logic [CHIP_IDX_W-1:0] w_chip_max;
    logic [CHIP_IDX_W-1:0] w_chip_nxt;
    logic [CHIP_IDX_W-1:0] w_chip_sh;
    logic [BIT_W-1:0]      w_bit_nxt;
    logic                  w_wrap;

    assign w_log2 = sf_to_log2(i_sf);
    // 2*SF chips per bit; SF16 span of 32 truncates to 0 and the -1
    // still lands on 31.
    assign w_span     = SPAN_UNIT << w_log2;
    assign w_chip_max = w_span[CHIP_IDX_W-1:0] - CHIP_IDX_W'(1);
    assign w_wrap     = (r_chip == w_chip_max);

    always_comb begin
        w_chip_nxt = r_chip;
        w_bit_nxt  = r_bit;
        if (i_clear) begin
            w_chip_nxt = '0;
            w_bit_nxt  = '0;
        end else if (i_enable) begin
            if (w_wrap) begin
                w_chip_nxt = '0;
                w_bit_nxt  = (r_bit == BIT_LAST) ? '0 : r_bit + BIT_W'(1);
            end else begin
                w_chip_nxt = r_chip + CHIP_IDX_W'(1);
            end
        end
    end

    // MSB is registered from the next chip value so it moves in
    // lockstep with o_chip_idx.
    assign w_chip_sh = w_chip_nxt >> w_log2;

    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            r_chip <= '0;
            r_msb  <= 1'b0;
            r_bit  <= '0;
        end else begin
            r_chip <= w_chip_nxt;
            r_msb  <= w_chip_sh[0];
            r_bit  <= w_bit_nxt;
        end
    end

    assign o_chip_idx           = r_chip;
    assign o_chip_idx_msb       = r_msb;
    assign o_last_chip_of_frame = i_enable & ~i_clear & w_wrap &
                                  (r_bit == BIT_LAST);

endmodule

// File: rtl/dcsk_tx_scheduler.sv
// dcsk_tx_scheduler: frame controller for the DCSK transmit modulator.
// Accepts a word (i_msg/i_msg_valid/o_msg_ready), latches o_msg/o_sf,
// pulses o_load_msg, runs chip/bit counters in SEND (o_chip_idx,
// o_chip_idx_msb, o_mod_en), inserts a guard gap, reports
// o_busy/o_frame_done/o_aborted and sticky o_err (i_mod_ready low in
// SEND). i_en freezes progress; i_abort drops any busy frame.
// Optional: define DCSK_TX_SCHED_FRAME_CNT_EN for o_frame_cnt and
// o_abort_cnt (16-bit wrapping completion/abort counters).
module dcsk_tx_scheduler
    import dcsk_tx_pkg::*;
#(
    parameter int MSG_WIDTH    = 32,
    parameter int GUARD_CYCLES = 4
) (
    input  logic                  i_clk,
    input  logic                  i_arst,
    input  logic                  i_en,
    input  logic [1:0]            i_sf,
    input  logic [MSG_WIDTH-1:0]  i_msg,
    input  logic                  i_msg_valid,
    output logic                  o_msg_ready,
    input  logic                  i_abort,
    input  logic                  i_mod_ready,
    output logic [MSG_WIDTH-1:0]  o_msg,
    output logic                  o_load_msg,
    output logic [1:0]            o_sf,
    output logic [CHIP_IDX_W-1:0] o_chip_idx,
    output logic                  o_chip_idx_msb,
    output logic                  o_mod_en,
    output logic                  o_busy,
    output logic                  o_frame_done,
    output logic                  o_aborted,
`ifdef DCSK_TX_SCHED_FRAME_CNT_EN
    output logic [15:0]           o_frame_cnt,
    output logic [15:0]           o_abort_cnt,
`endif
    output logic                  o_err
);

    localparam int GW    = $clog2(GUARD_CYCLES + 2);
    localparam int GLAST = (GUARD_CYCLES > 0) ? GUARD_CYCLES - 1 : 0;

    tx_sched_state_t  r_state;
    tx_sched_state_t  w_state_nxt;
    logic [GW-1:0]    r_guard;
    logic [MSG_WIDTH-1:0] r_msg;
    logic [1:0]       r_sf;
    logic             r_frame_done;
    logic             r_aborted;
    logic             r_err;

    logic             w_accept;
    logic             w_abort;
    logic             w_done;
    logic             w_guard_last;
    logic             w_cnt_en;
    logic             w_last_chip;

    assign o_msg_ready  = (r_state == IDLE) & i_en;
    assign w_accept     = o_msg_ready & i_msg_valid;
    assign w_abort      = i_abort & (r_state != IDLE);
    assign w_guard_last = (r_guard == GW'(GLAST));
    assign w_cnt_en     = (r_state == SEND) & i_en & ~w_abort;

    // Abort wins over both a stalled enable and normal completion.
    always_comb begin
        w_state_nxt = r_state;
        w_done      = 1'b0;
        if (w_abort) begin
            w_state_nxt = IDLE;
        end else if (i_en) begin
            unique case (r_state)
                IDLE: if (i_msg_valid) w_state_nxt = LOAD;
                LOAD: w_state_nxt = SEND;
                SEND: begin
                    if (w_last_chip) begin
                        if (GUARD_CYCLES == 0) begin
                            w_state_nxt = IDLE;
                            w_done      = 1'b1;
                        end else begin
                            w_state_nxt = GUARD;
                        end
                    end
                end
                GUARD: begin
                    if (w_guard_last) begin
                        w_state_nxt = IDLE;
                        w_done      = 1'b1;
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            r_state      <= IDLE;
            r_guard      <= '0;
            r_msg        <= '0;
            r_sf         <= '0;
            r_frame_done <= 1'b0;
            r_aborted    <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_frame_done <= w_done;
            r_aborted    <= w_abort;
            if (w_accept) begin
                r_msg <= i_msg;
                r_sf  <= i_sf;
            end
            if (r_state == SEND && !i_mod_ready) begin
                r_err <= 1'b1;
            end
            if (w_abort || r_state != GUARD) begin
                r_guard <= '0;
            end else if (i_en) begin
                r_guard <= w_guard_last ? '0 : r_guard + GW'(1);
            end
        end
    end

`ifdef DCSK_TX_SCHED_FRAME_CNT_EN
    logic [15:0] r_frame_cnt;
    logic [15:0] r_abort_cnt;

    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            r_frame_cnt <= '0;
            r_abort_cnt <= '0;
        end else begin
            if (r_frame_done) r_frame_cnt <= r_frame_cnt + 16'd1;
            if (r_aborted)    r_abort_cnt <= r_abort_cnt + 16'd1;
        end
    end

    assign o_frame_cnt = r_frame_cnt;
    assign o_abort_cnt = r_abort_cnt;
`endif

    chip_bit_counter #(
        .MSG_WIDTH (MSG_WIDTH)
    ) u_cnt (
        .i_clk                (i_clk),
        .i_arst               (i_arst),
        .i_clear              (w_abort),
        .i_enable             (w_cnt_en),
        .i_sf                 (r_sf),
        .o_chip_idx           (o_chip_idx),
        .o_chip_idx_msb       (o_chip_idx_msb),
        .o_last_chip_of_frame (w_last_chip)
    );

    // Held in LOAD while disabled; fires once i_en returns.
    assign o_load_msg   = (r_state == LOAD) & i_en & ~i_abort;
    assign o_mod_en     = (r_state == SEND) & i_en;
    assign o_busy       = (r_state != IDLE);
    assign o_msg        = r_msg;
    assign o_sf         = r_sf;
    assign o_frame_done = r_frame_done;
    assign o_aborted    = r_aborted;
    assign o_err        = r_err;

endmodule

// File: tb/tb_dcsk_tx_scheduler.sv
// Self-checking bench for dcsk_tx_scheduler.
// Scoreboard of accepted words checked at load, chip walk and frame end.
module tb_dcsk_tx_scheduler;

    import spreading_factors_pkg::*;

    localparam int MW = 32;
    localparam int GC = 4;

    logic          clk = 1'b0;
    logic          i_arst;
    logic          i_en;
    logic [1:0]    i_sf;
    logic [MW-1:0] i_msg;
    logic          i_msg_valid;
    logic          o_msg_ready;
    logic          i_abort;
    logic          i_mod_ready;
    logic [MW-1:0] o_msg;
    logic          o_load_msg;
    logic [1:0]    o_sf;
    logic [4:0]    o_chip_idx;
    logic          o_chip_idx_msb;
    logic          o_mod_en;
    logic          o_busy;
    logic          o_frame_done;
    logic          o_aborted;
    logic          o_err;
`ifdef DCSK_TX_SCHED_FRAME_CNT_EN
    logic [15:0]   o_frame_cnt;
    logic [15:0]   o_abort_cnt;
`endif

    dcsk_tx_scheduler #(.MSG_WIDTH(MW), .GUARD_CYCLES(GC)) dut (
        .i_clk          (clk),
        .i_arst         (i_arst),
        .i_en           (i_en),
        .i_sf           (i_sf),
        .i_msg          (i_msg),
        .i_msg_valid    (i_msg_valid),
        .o_msg_ready    (o_msg_ready),
        .i_abort        (i_abort),
        .i_mod_ready    (i_mod_ready),
        .o_msg          (o_msg),
        .o_load_msg     (o_load_msg),
        .o_sf           (o_sf),
        .o_chip_idx     (o_chip_idx),
        .o_chip_idx_msb (o_chip_idx_msb),
        .o_mod_en       (o_mod_en),
        .o_busy         (o_busy),
        .o_frame_done   (o_frame_done),
        .o_aborted      (o_aborted),
`ifdef DCSK_TX_SCHED_FRAME_CNT_EN
        .o_frame_cnt    (o_frame_cnt),
        .o_abort_cnt    (o_abort_cnt),
`endif
        .o_err          (o_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [MW-1:0] msg;
        logic [1:0]    sf;
        int            t_acc;
        bit            abort;
    } exp_t;

    exp_t q[$];
    exp_t cur;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    bit   in_frame = 0;
    bit   abort_next = 0;
    int   cnt = 0;
    int   stall = 0;
    int   load_cyc = 0;
    int   sfv = 2;
    int   n_done = 0;
    int   n_abt = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     tag, got, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard monitor, sampled on the falling edge.
    always @(negedge clk) begin
        exp_t e;
        if (i_arst) begin
            in_frame = 0;
            q.delete();
        end else begin
            if (i_msg_valid && o_msg_ready) begin
                e.msg   = i_msg;
                e.sf    = i_sf;
                e.t_acc = cyc;
                e.abort = abort_next;
                q.push_back(e);
            end
            if (o_aborted) begin
                n_abt++;
                chk("abort_in_frame", 64'(in_frame), 1);
                if (in_frame) chk("abort_expected", 64'(cur.abort), 1);
                chk("abort_chip", 64'(o_chip_idx), 0);
                chk("abort_busy", 64'(o_busy), 0);
                in_frame = 0;
            end else if (o_frame_done) begin
                n_done++;
                chk("done_in_frame", 64'(in_frame), 1);
                if (in_frame) begin
                    chk("done_not_abort", 64'(cur.abort), 0);
                    chk("send_len", 64'(cnt), 64'(MW * 2 * sfv));
                    chk("done_time", 64'(cyc),
                        64'(load_cyc + 1 + MW * 2 * sfv + GC + stall));
                end
                in_frame = 0;
            end
            if (o_load_msg) begin
                if (q.size() == 0) begin
                    chk("load_unexpected", 64'(o_load_msg), 0);
                end else begin
                    cur = q.pop_front();
                    chk("load_time", 64'(cyc), 64'(cur.t_acc + 1));
                    chk("msg", 64'(o_msg), 64'(cur.msg));
                    chk("sf", 64'(o_sf), 64'(cur.sf));
                    in_frame = 1;
                    cnt      = 0;
                    stall    = 0;
                    load_cyc = cyc;
                    sfv      = 2 << cur.sf;
                end
            end else if (in_frame) begin
                chk("chip", 64'(o_chip_idx), 64'(cnt % (2 * sfv)));
                chk("msb", 64'(o_chip_idx_msb),
                    64'((cnt % (2 * sfv)) >= sfv));
                chk("busy", 64'(o_busy), 1);
                chk("ready_busy", 64'(o_msg_ready), 0);
                if (!i_en) begin
                    stall++;
                    chk("mod_en_off", 64'(o_mod_en), 0);
                end
                if (o_mod_en) cnt++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_accept();
        bit ok = 0;
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            if (o_msg_ready) begin
                ok = 1;
                break;
            end
        end
        chk("accept_timeout", 64'(ok), 1);
        tick();
    endtask

    task automatic send(input logic [1:0] sf, input logic [MW-1:0] msg);
        i_sf        = sf;
        i_msg       = msg;
        i_msg_valid = 1'b1;
        wait_accept();
        i_msg_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok = 0;
        for (int k = 0; k < 3000; k++) begin
            tick();
            if (!o_busy && q.size() == 0 && !in_frame) begin
                ok = 1;
                break;
            end
        end
        chk("idle_timeout", 64'(ok), 1);
    endtask

    task automatic wait_cnt(input int n);
        bit ok = 0;
        for (int k = 0; k < 3000; k++) begin
            tick();
            if (in_frame && cnt >= n) begin
                ok = 1;
                break;
            end
        end
        chk("cnt_timeout", 64'(ok), 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        i_arst      = 1'b1;
        i_en        = 1'b1;
        i_sf        = SF2;
        i_msg       = '0;
        i_msg_valid = 1'b0;
        i_abort     = 1'b0;
        i_mod_ready = 1'b1;
        #2;
        chk("rst_ready", 64'(o_msg_ready), 1);
        chk("rst_busy", 64'(o_busy), 0);
        chk("rst_chip", 64'(o_chip_idx), 0);
        chk("rst_err", 64'(o_err), 0);
        repeat (3) @(posedge clk);
        #1;
        i_arst = 1'b0;
        chk("idle_ready", 64'(o_msg_ready), 1);

        // Single SF4 frame.
        send(SF4, 32'hA5C3_0F17);
        wait_idle();

        // Back-to-back SF16 then SF2 with valid held.
        i_sf        = SF16;
        i_msg       = 32'h1357_9BDF;
        i_msg_valid = 1'b1;
        wait_accept();
        i_sf  = SF2;
        i_msg = 32'h2468_ACE0;
        wait_accept();
        i_msg_valid = 1'b0;
        i_sf        = SF8;
        wait_idle();

        // Abort at SEND cycle 100, then a clean frame.
        abort_next = 1;
        send(SF4, 32'hDEAD_BEEF);
        abort_next = 0;
        wait_cnt(100);
        i_abort = 1'b1;
        tick();
        i_abort = 1'b0;
        wait_idle();
        chk("abort_seen", 64'(n_abt), 1);
        send(SF4, 32'h0F0F_F0F0);
        wait_idle();

        // Abort while idle is ignored.
        i_abort = 1'b1;
        tick();
        i_abort = 1'b0;
        chk("idle_abort", 64'(o_aborted), 0);
        chk("idle_abort_busy", 64'(o_busy), 0);

        // Enable low for 10 cycles mid-SEND.
        send(SF4, 32'h8000_0001);
        wait_cnt(50);
        i_en = 1'b0;
        repeat (10) tick();
        i_en = 1'b1;
        wait_idle();

        // Sticky error.
        chk("err_pre", 64'(o_err), 0);
        send(SF2, 32'h5555_AAAA);
        wait_cnt(20);
        i_mod_ready = 1'b0;
        tick();
        i_mod_ready = 1'b1;
        chk("err_set", 64'(o_err), 1);
        wait_idle();
        send(SF4, 32'h3C3C_C3C3);
        wait_idle();
        chk("err_sticky", 64'(o_err), 1);
`ifdef DCSK_TX_SCHED_FRAME_CNT_EN
        chk("frame_cnt_pre", 64'(o_frame_cnt), 7);
        chk("abort_cnt_pre", 64'(o_abort_cnt), 1);
`endif

        // Asynchronous reset mid-SEND.
        send(SF8, 32'hFFFF_0000);
        wait_cnt(30);
        #2;
        i_arst = 1'b1;
        #1;
        chk("arst_msg", 64'(o_msg), 0);
        chk("arst_sf", 64'(o_sf), 0);
        chk("arst_chip", 64'(o_chip_idx), 0);
        chk("arst_msb", 64'(o_chip_idx_msb), 0);
        chk("arst_mod_en", 64'(o_mod_en), 0);
        chk("arst_busy", 64'(o_busy), 0);
        chk("arst_err", 64'(o_err), 0);
        chk("arst_ready", 64'(o_msg_ready), 1);
        tick();
        tick();
        i_arst = 1'b0;
        chk("post_rst_ready", 64'(o_msg_ready), 1);
        tick();
        chk("post_rst_busy", 64'(o_busy), 0);

        send(SF4, 32'h0123_4567);
        wait_idle();

        chk("q_empty", 64'(q.size()), 0);
        chk("frames_done", 64'(n_done), 8);
        chk("aborts", 64'(n_abt), 1);
`ifdef DCSK_TX_SCHED_FRAME_CNT_EN
        chk("frame_cnt", 64'(o_frame_cnt), 1);
        chk("abort_cnt", 64'(o_abort_cnt), 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dcsk_tx_scheduler.md
Name: dcsk_tx_scheduler

Overview:
- Frame-level controller for the DCSK transmit modulator.
- Accepts one message word per frame over a valid/ready handshake.
- Latches the spreading factor at frame start, then pulses the message load.
- Generates the chip index, and therefore the chip-index MSB that selects the reference half or the data half, for every bit of the frame.
- Inserts a guard interval between frames and reports done/abort status to the upstream packetiser.

Parameters:
- MSG_WIDTH, 32: bits per message/frame; must be ≥ 1.
- GUARD_CYCLES, 4: idle clocks between the end of SEND and return to IDLE; 0 means the GUARD state is skipped.

Ports:
- i_clk  in  1  system clock; all logic on the rising edge.
- i_arst  in  1  asynchronous, active-high reset.
- i_en  in  1  global enable; low freezes state and counters.
- i_sf  in  2  requested spreading factor (SF2/SF4/SF8/SF16 encoding); sampled only at accept.
- i_msg  in  MSG_WIDTH  message word.
- i_msg_valid  in  1  upstream word valid.
- o_msg_ready  out  1  scheduler can accept a word.
- i_abort  in  1  synchronous abort of the current frame.
- i_mod_ready  in  1  modulator not empty (its ready-to-send indication).
- o_msg  out  MSG_WIDTH  registered word to the modulator message input.
- o_load_msg  out  1  one-cycle load pulse to the modulator.
- o_sf  out  2  latched spreading factor to the modulator.
- o_chip_idx  out  5  chip counter within the current bit, 0..2*SF-1.
- o_chip_idx_msb  out  1  high during the data half (o_chip_idx ≥ SF).
- o_mod_en  out  1  modulator enable; high in SEND while i_en is high.
- o_busy  out  1  state is not IDLE.
- o_frame_done  out  1  one-cycle pulse on normal frame completion.
- o_aborted  out  1  one-cycle pulse when an abort takes effect.
- o_err  out  1  sticky flag: i_mod_ready was low during SEND.

Behaviour:
- Reset (i_arst high, asynchronous): state IDLE; o_msg, o_sf, o_chip_idx, bit counter, guard counter, o_load_msg, o_frame_done, o_aborted and o_err are all 0.
- o_msg_ready = (state == IDLE) & i_en, decoded from registered state, so it reads 1 during reset whenever i_en is high.
- States: IDLE, LOAD, SEND, GUARD.
- IDLE → LOAD on i_msg_valid & o_msg_ready at cycle T. In the same edge, i_msg is registered into o_msg and i_sf into o_sf.
- LOAD (cycle T+1): o_load_msg = 1 for exactly one cycle; always moves to SEND.
- SEND starts at T+2 with o_chip_idx = 0.
  - o_chip_idx increments each enabled cycle and wraps from 2*SF-1 to 0.
  - On each wrap the bit counter increments.
  - On the wrap with bit counter == MSG_WIDTH-1: go to GUARD, or to IDLE if GUARD_CYCLES == 0.
  - SEND therefore lasts exactly MSG_WIDTH*2*SF enabled cycles.
- o_chip_idx_msb = o_chip_idx[log2(SF)], registered together with o_chip_idx. SF2 uses bit 1, SF4 bit 2, SF8 bit 3, SF16 bit 4.
- GUARD: counts GUARD_CYCLES enabled cycles, then IDLE. o_frame_done pulses in the first IDLE cycle after a completed frame.
- Outside SEND, o_chip_idx and o_chip_idx_msb are 0, so the modulator sees a clean MSB edge at every frame start.
- i_en low: state, chip counter, bit counter and guard counter hold. o_mod_en = 0. o_load_msg is held off and fires when i_en returns.
- i_abort in any non-IDLE state: IDLE next cycle, all counters cleared, o_aborted pulses one cycle, no o_frame_done. Abort has priority over i_en low and over the normal completion transition. Abort in IDLE is ignored.
- o_err: set if i_mod_ready == 0 in any SEND cycle; cleared only by reset.
- i_sf changes while busy have no effect until the next accept.

Optional Feature:
- Macro: DCSK_TX_SCHED_FRAME_CNT_EN.
- Defined: adds outputs o_frame_cnt [15:0] and o_abort_cnt [15:0].
  - o_frame_cnt increments on each o_frame_done; o_abort_cnt increments on each o_aborted.
  - Both wrap 0xFFFF → 0 and reset to 0.
- Undefined: these ports and registers are absent; all other behaviour is identical.

Decomposition:
- Shared package dcsk_tx_pkg:
  - state enum tx_sched_state_t {IDLE, LOAD, SEND, GUARD};
  - function sf_to_log2(), mapping SF2..SF16 to 1..4;
  - localparam CHIP_IDX_W = 5.
- SF encodings are reused from the existing spreading_factors_pkg.
- One sub-module is natural: chip_bit_counter.
  - Contains the chip counter, bit counter and MSB tap.
  - Inputs: clear, enable, SF.
  - Output: last_chip_of_frame strobe.

Test Plan:
- MSG_WIDTH=32, GUARD_CYCLES=4, SF4, accept at T → o_load_msg at T+1; o_chip_idx cycles 0..7 from T+2; o_chip_idx_msb high on 4..7; o_mod_en high for 256 cycles; o_frame_done at T+262.
- SF16 then SF2 frames back-to-back with valid held high → each o_sf is latched correctly; SEND lengths 1024 and 128; o_msg_ready low throughout busy.
- i_abort at SEND cycle 100 → IDLE next cycle; o_aborted = 1 for one cycle; counters 0; no o_frame_done; next frame starts at chip 0.
- i_en low for 10 cycles mid-SEND → o_chip_idx frozen; o_mod_en = 0; total SEND active cycles still 256 (SF4).
- i_mod_ready forced 0 for one SEND cycle → o_err = 1 and stays set through the following frames until i_arst.
- Reset asserted mid-SEND → all outputs 0 immediately (asynchronous); IDLE with o_msg_ready = 1 after release.
